// File: rtl/proc_pkg.sv
// Shared processor definitions: address/data widths, reset PC and fetch FSM states.
// Kept separate so the core decoder can reuse the same widths and state encoding.
package proc_pkg;

  localparam int          A        = 16;
  localparam int          W        = 32;
  localparam int unsigned RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instruction} pairs between fetch and core.
// Flush has priority over push/pop so a redirect never leaves wrong-path words behind.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 48,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // A full buffer may still accept a word when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch front end: one outstanding imem request,
// fetched words buffered with their PC, branch redirect and halt handling.
module pc_fetch_unit
  import proc_pkg::*;
#(
  parameter int             A        = proc_pkg::A,
  parameter int             W        = proc_pkg::W,
  parameter logic [A-1:0]   RESET_PC = A'(proc_pkg::RESET_PC),
  parameter int             DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [A-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [W-1:0] instr,
  output logic [A-1:0] instr_pc,
  input  logic         instr_ready,
  input  logic         branch_valid,
  input  logic [A-1:0] branch_target,
  input  logic         halt,
  output logic         busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [A-1:0]  pc;
  logic          drop;
  logic          ack;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [A-1:0]  pc_eff;
  logic [A-1:0]  ack_pc;
  logic [A+W-1:0] head;

  assign ack        = (state == REQ) && imem_ack;
  assign pop        = instr_valid && instr_ready;
  assign push       = ack && !drop && !branch_valid;
  assign count_next = count + CW'(push) - CW'(pop);
  assign pc_eff     = branch_valid ? branch_target : pc;

  // PC for the request that follows an ack: redirect, pending redirect, or sequential.
  always_comb begin
    ack_pc = pc + A'(1);
    if (branch_valid) ack_pc = branch_target;
    else if (drop)    ack_pc = pc;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .DW    (A + W),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({imem_addr, imem_rdata}),
    .pop       (pop),
    .flush     (branch_valid),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign instr_valid       = !empty;
  assign {instr_pc, instr} = head;
  assign busy              = imem_req || !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc        <= pc_eff;
          imem_addr <= pc_eff;
          if (halt) begin
            state <= HALTED;
          end else if (branch_valid || !full) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        HALTED: begin
          pc        <= pc_eff;
          imem_addr <= pc_eff;
          if (!halt) state <= IDLE;
        end
        REQ: begin
          if (imem_ack) begin
            drop      <= 1'b0;
            pc        <= ack_pc;
            imem_addr <= ack_pc;
            if (halt || !(branch_valid || count_next < CW'(DEPTH))) begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end else if (branch_valid) begin
            // Address must stay put until the ack; remember to discard its data.
            pc   <= branch_target;
            drop <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
